// File: rtl/fetch_credit_controller.sv
// rtl/fetch_credit_controller.sv - credit-gated sequential fetch into the decode instruction queue
// Issues I-cache requests only when queue space is guaranteed; drains stale responses after redirects.
module fetch_credit_controller #(
  parameter int          QUEUE_DEPTH  = 8,
  parameter int          MAX_INFLIGHT = 4,
  parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           redirect_valid,
  input  logic [31:0]                    redirect_pc,
  output logic                           ic_req_valid,
  input  logic                           ic_req_ready,
  output logic [31:0]                    ic_req_pc,
  input  logic                           ic_resp_valid,
  input  logic [31:0]                    ic_resp_pc,
  input  logic [31:0]                    ic_resp_data,
  output logic                           q_wr_valid,
  output logic [31:0]                    q_wr_pc,
  output logic [31:0]                    q_wr_data,
  input  logic                           q_pop,
  output logic                           q_flush,
  output logic [$clog2(QUEUE_DEPTH):0]   occupancy
);

  localparam int OW = $clog2(QUEUE_DEPTH) + 1;
  localparam int IW = $clog2(MAX_INFLIGHT) + 1;
  localparam int SW = ((OW > IW) ? OW : IW) + 1;

  typedef enum logic {FETCH, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [IW-1:0] inflight_q, inflight_d;
  logic [OW-1:0] occupancy_q, occupancy_d;

  logic [SW-1:0] committed;
  logic          credit_ok;
  logic          req_valid;
  logic          req_fire;
  logic          resp_live;
  logic          wr_valid;
  logic          pop_ok;
  logic          flush;

  always_comb begin
    // Occupancy plus in-flight is compared one bit wider so the sum can never wrap.
    committed = SW'(occupancy_q) + SW'(inflight_q);
    credit_ok = (committed < SW'(QUEUE_DEPTH)) && (inflight_q < IW'(MAX_INFLIGHT));

    flush     = rst_n && redirect_valid;
    req_valid = rst_n && (state_q == FETCH) && credit_ok && !redirect_valid;
    req_fire  = req_valid && ic_req_ready;
    // A response with nothing outstanding cannot belong to us and is ignored.
    resp_live = rst_n && ic_resp_valid && (inflight_q != '0);
    wr_valid  = resp_live && (state_q == FETCH) && !redirect_valid;
    pop_ok    = q_pop && (occupancy_q != '0);

    inflight_d = inflight_q;
    unique case ({req_fire, resp_live})
      2'b10:   inflight_d = inflight_q + IW'(1);
      2'b01:   inflight_d = inflight_q - IW'(1);
      default: inflight_d = inflight_q;
    endcase

    occupancy_d = occupancy_q;
    if (redirect_valid) begin
      occupancy_d = '0;
    end else begin
      unique case ({wr_valid, pop_ok})
        2'b10:   occupancy_d = occupancy_q + OW'(1);
        2'b01:   occupancy_d = occupancy_q - OW'(1);
        default: occupancy_d = occupancy_q;
      endcase
    end

    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (req_fire) begin
      pc_d = pc_q + 32'd4;
    end

    state_d = state_q;
    if (redirect_valid || (state_q == DRAIN)) begin
      state_d = (inflight_d != '0) ? DRAIN : FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      inflight_q  <= '0;
      occupancy_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inflight_q  <= inflight_d;
      occupancy_q <= occupancy_d;
    end
  end

  assign ic_req_valid = req_valid;
  assign ic_req_pc    = pc_q;
  assign q_wr_valid   = wr_valid;
  assign q_wr_pc      = ic_resp_pc;
  assign q_wr_data    = ic_resp_data;
  assign q_flush      = flush;
  assign occupancy    = occupancy_q;

endmodule
